// File: rtl/ftdi_order_decoder.sv
// FTDI receive-FIFO command decoder.
// Parses header/address/length and issues register write/read strobes.
module ftdi_order_decoder #(
  parameter int unsigned TO_W = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [7:0]  ri_data,
  input  logic        ri_empty,
  output logic        ri_read,
  input  logic        pcreadfifofull,
  output logic [7:0]  header,
  output logic [7:0]  address,
  output logic [15:0] length,
  output logic [7:0]  value,
  output logic        write,
  output logic        read,
  output logic        abort,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_HDR   = 4'd0,
    S_ADDR  = 4'd1,
    S_LENH  = 4'd2,
    S_LENL  = 4'd3,
    S_WDATA = 4'd4,
    S_WSTB  = 4'd5,
    S_READ  = 4'd6
  } state_t;

  state_t          state_q, state_d;
  logic            pend, pend_d;
  logic [TO_W-1:0] cnt, cnt_d, cnt_inc;
  logic [7:0]      header_d, address_d, value_d;
  logic [15:0]     length_d, len_new;
  logic            write_d, read_d, abort_d;
  logic            fetch, timed, capture, to_hit;

  assign state   = state_q;
  assign fetch   = (state_q == S_HDR) || (state_q == S_ADDR)
                || (state_q == S_LENH) || (state_q == S_LENL)
                || (state_q == S_WDATA);
  assign timed   = fetch && (state_q != S_HDR);
  assign capture = fetch && pend;
  assign ri_read = fetch && !pend && !ri_empty;
  assign cnt_inc = cnt + 1'b1;
  assign to_hit  = (TIMEOUT != '0) && timed && !capture
                && (cnt_inc == TIMEOUT);
  assign len_new = {length[15:8], ri_data};

  // State and output registers; reset drops any partial packet.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_HDR;
      pend    <= 1'b0;
      cnt     <= '0;
      header  <= '0;
      address <= '0;
      length  <= '0;
      value   <= '0;
      write   <= 1'b0;
      read    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend    <= pend_d;
      cnt     <= cnt_d;
      header  <= header_d;
      address <= address_d;
      length  <= length_d;
      value   <= value_d;
      write   <= write_d;
      read    <= read_d;
      abort   <= abort_d;
    end
  end

  // Byte fetch, packet parsing, strobe generation and timeout abort.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend;
    cnt_d     = '0;
    header_d  = header;
    address_d = address;
    length_d  = length;
    value_d   = value;
    write_d   = 1'b0;
    read_d    = 1'b0;
    abort_d   = 1'b0;
    if (ri_read) pend_d = 1'b1;
    if (capture) pend_d = 1'b0;
    if (timed && !capture) cnt_d = cnt_inc;
    unique case (state_q)
      S_HDR: begin
        if (capture) begin
          header_d = ri_data;
          if (ri_data[7:6] == 2'b01 || ri_data[7:6] == 2'b10)
            state_d = S_ADDR;
          else
            abort_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (capture) begin
          address_d = ri_data;
          state_d   = S_LENH;
        end
      end
      S_LENH: begin
        if (capture) begin
          length_d[15:8] = ri_data;
          state_d        = S_LENL;
        end
      end
      S_LENL: begin
        if (capture) begin
          length_d = len_new;
          if (len_new == 16'd0)
            state_d = S_HDR;
          else if (header[7:6] == 2'b01)
            state_d = S_WDATA;
          else
            state_d = S_READ;
        end
      end
      S_WDATA: begin
        if (capture) begin
          value_d = ri_data;
          write_d = 1'b1;
          state_d = S_WSTB;
        end
      end
      S_WSTB: begin
        length_d = length - 16'd1;
        if (header[5]) address_d = address + 8'd1;
        state_d = (length == 16'd1) ? S_HDR : S_WDATA;
      end
      S_READ: begin
        if (read) begin
          length_d = length - 16'd1;
          if (header[5]) address_d = address + 8'd1;
          if (length == 16'd1) state_d = S_HDR;
        end else if (!pcreadfifofull) begin
          read_d = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
    if (to_hit) begin
      abort_d = 1'b1;
      state_d = S_HDR;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end
  end

endmodule
